// File: rtl/aes_key_sched_multi.sv
// Run-time AES-128/192/256 key expansion, one word per cycle, into a 60-word round-key buffer; AES_KS_ZEROIZE_EN adds a buffer wipe on zeroize.
// Latency: word i written T0+1+i, done one cycle after the last write; round-key reads take RD_REG cycles.
// Backpressure: none; start is ignored while busy, reads never stall (rd_err until the round is written).
module aes_key_sched_multi #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RD_REG       = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         cfg_err,
    input  logic         rd_en,
    input  logic [3:0]   rd_round,
    input  logic         rd_inv,
    output logic         rd_valid,
    output logic         rd_err,
    output logic [127:0] rd_key,
    input  logic         zeroize
);

    localparam int MAX_NK = MAX_KEY_BITS / 32;
    localparam int MAX_NR = MAX_NK + 6;
    localparam int BUF_W  = 4 * (MAX_NR + 1);
    localparam logic [5:0] BUF_LAST = 6'(BUF_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_ZERO} state_t;
`ifdef AES_KS_ZEROIZE_EN
    localparam state_t ZERO_NEXT = S_ZERO;
`else
    localparam state_t ZERO_NEXT = S_IDLE;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ s;
            s = xtime(s);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] iv;
        sq = x;
        iv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            iv = gf_mul(iv, sq);
        end
        return iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
                  ^ {iv[3:0], iv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t                   state, state_nx;
    logic [1:0]               klen;
    logic [255:0]             key_sh;
    logic [MAX_NK-1:0][31:0]  win;
    logic [31:0]              kbuf [BUF_W];
    logic [5:0]               idx;
    logic [2:0]               mod_cnt;
    logic [7:0]               rcon;
    logic [MAX_NR:0]          rk_vld;
    logic                     done_q, cfg_err_q;

    logic [3:0]  nr;
    logic [2:0]  nk_m1;
    logic [5:0]  last_w;
    logic        key_ok;
    logic        accept, reject, wr_en, zclr;

    assign nr     = 4'd10 + {1'b0, klen, 1'b0};
    assign nk_m1  = 3'd3 + {klen, 1'b0};
    assign last_w = {nr, 2'b11};
    assign key_ok = (key_len != 2'd3) && ((128 + 64 * int'(key_len)) <= MAX_KEY_BITS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (zeroize)                state_nx = ZERO_NEXT;
                else if (start && key_ok)   state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (zeroize)                      state_nx = ZERO_NEXT;
                else if (idx == {3'b000, nk_m1})  state_nx = S_EXPAND;
            end
            S_EXPAND: begin
                if (zeroize)              state_nx = ZERO_NEXT;
                else if (idx == last_w)   state_nx = S_IDLE;
            end
            S_ZERO: begin
                if (idx == BUF_LAST)      state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != S_IDLE);
        accept = 1'b0;
        reject = 1'b0;
        wr_en  = 1'b0;
        zclr   = 1'b0;
        case (state)
            S_IDLE: begin
                zclr   = zeroize;
                accept = start && !zeroize && key_ok;
                reject = start && !zeroize && !key_ok;
            end
            S_LOAD, S_EXPAND: begin
                zclr  = zeroize;
                wr_en = !zeroize;
            end
            S_ZERO:  wr_en = 1'b1;
            default: ;
        endcase
    end

    assign done    = done_q;
    assign cfg_err = cfg_err_q;

    // win[0] is w[i-1], win[Nk-1] is w[i-Nk]; mod_cnt tracks i mod Nk
    logic [31:0] prev, far, sw_in, sw, tmp, exp_word, wr_dat;
    always_comb begin
        prev     = win[0];
        far      = win[nk_m1];
        sw_in    = (mod_cnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        sw       = sub_word(sw_in);
        if (mod_cnt == 3'd0)                          tmp = sw ^ {rcon, 24'h0};
        else if (klen == 2'd2 && mod_cnt == 3'd4)     tmp = sw;
        else                                          tmp = prev;
        exp_word = far ^ tmp;
        case (state)
            S_LOAD:   wr_dat = key_sh[255:224];
            S_EXPAND: wr_dat = exp_word;
            default:  wr_dat = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            klen      <= 2'd0;
            key_sh    <= '0;
            win       <= '0;
            idx       <= '0;
            mod_cnt   <= '0;
            rcon      <= '0;
            rk_vld    <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= (state == S_EXPAND) && wr_en && (idx == last_w);
            cfg_err_q <= reject;
            if (zclr) begin
                key_sh  <= '0;
                win     <= '0;
                idx     <= '0;
                mod_cnt <= '0;
                rcon    <= '0;
                rk_vld  <= '0;
            end else if (accept) begin
                klen    <= key_len;
                key_sh  <= key_in;
                idx     <= '0;
                mod_cnt <= '0;
                rcon    <= 8'h01;
                rk_vld  <= '0;
            end else if (wr_en) begin
                idx <= idx + 6'd1;
                if (state == S_ZERO) begin
                    win <= '0;
                end else begin
                    key_sh  <= {key_sh[223:0], 32'h0};
                    win     <= {win[MAX_NK-2:0], wr_dat};
                    mod_cnt <= (mod_cnt == nk_m1) ? 3'd0 : mod_cnt + 3'd1;
                    if (idx[1:0] == 2'b11) rk_vld[idx[5:2]] <= 1'b1;
                    if (state == S_EXPAND && mod_cnt == 3'd0) rcon <= xtime(rcon);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) kbuf[idx] <= wr_dat;
    end

    // The bitmap is sampled before this edge's update, so a round completing now still reads as error
    logic        rd_over, rd_bad, rd_err_c;
    logic [3:0]  rd_phys, rd_sel;
    logic [127:0] rd_dat, rd_key_c;
    always_comb begin
        rd_over  = (rd_round > nr);
        rd_phys  = rd_inv ? (nr - rd_round) : rd_round;
        rd_sel   = rd_over ? 4'd0 : rd_phys;
        rd_bad   = rd_over || !rk_vld[rd_sel];
        rd_dat   = {kbuf[{rd_sel, 2'd0}], kbuf[{rd_sel, 2'd1}],
                    kbuf[{rd_sel, 2'd2}], kbuf[{rd_sel, 2'd3}]};
        rd_err_c = rd_en && rd_bad;
        rd_key_c = (rd_en && !rd_bad) ? rd_dat : '0;
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_err   <= 1'b0;
                    rd_key   <= '0;
                end else begin
                    rd_valid <= rd_en;
                    rd_err   <= rd_err_c;
                    rd_key   <= rd_key_c;
                end
            end
        end else begin : g_rd_comb
            assign rd_valid = rd_en;
            assign rd_err   = rd_err_c;
            assign rd_key   = rd_key_c;
        end
    endgenerate

endmodule

// File: tb/tb_aes_key_sched_multi.sv
// Directed bench for aes_key_sched_multi: FIPS-197 key vectors, read overlap, rejection, zeroize and reset.
module tb_aes_key_sched_multi;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key_in = '0;
    logic         busy, done, cfg_err;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_round = 4'd0;
    logic         rd_inv = 1'b0;
    logic         rd_valid, rd_err;
    logic [127:0] rd_key;
    logic         zeroize = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_1  = 128'h10111213141516175846f2f95c43f4fe;
    localparam logic [127:0] R192_12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
    localparam logic [127:0] R256_0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R256_1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R256_14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    localparam logic [255:0] K128 = {R128_0, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = {R256_0, R256_1};

`ifdef AES_KS_ZEROIZE_EN
    localparam int ZERO_BUSY = 60;
`else
    localparam int ZERO_BUSY = 0;
`endif

    aes_key_sched_multi #(.MAX_KEY_BITS(256), .RD_REG(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .rd_en    (rd_en),
        .rd_round (rd_round),
        .rd_inv   (rd_inv),
        .rd_valid (rd_valid),
        .rd_err   (rd_err),
        .rd_key   (rd_key),
        .zeroize  (zeroize)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_ks(input logic [1:0] kl, input logic [255:0] key);
        start   = 1'b1;
        key_len = kl;
        key_in  = key;
        tick();
        start   = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] r, input logic inv,
                            input logic exp_err, input logic [127:0] exp_key);
        rd_en    = 1'b1;
        rd_round = r;
        rd_inv   = inv;
        tick();
        rd_en    = 1'b0;
        rd_inv   = 1'b0;
        chk({tag, "_vld"}, 128'(rd_valid), 128'd1);
        chk({tag, "_err"}, 128'(rd_err), 128'(exp_err));
        chk({tag, "_key"}, rd_key, exp_key);
    endtask

    // The cycle carrying start is cycle 0; returns -1 if done never appears
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (done) begin
                cyc = k + 1;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int nb;
        int dcnt;

        tick();
        tick();
        chk("rst_busy",     128'(busy),     128'd0);
        chk("rst_done",     128'(done),     128'd0);
        chk("rst_cfg_err",  128'(cfg_err),  128'd0);
        chk("rst_rd_valid", 128'(rd_valid), 128'd0);
        chk("rst_rd_key",   rd_key,         128'd0);
        rst_n = 1'b1;
        tick();

        // AES-128
        start_ks(2'd0, K128);
        chk("busy_128", 128'(busy), 128'd1);
        wait_done(cyc);
        chk("done_cyc_128", 128'(cyc), 128'd45);
        chk("busy_after_128", 128'(busy), 128'd0);
        tick();
        chk("done_one_pulse_128", 128'(done), 128'd0);
        read_chk("r10_128", 4'd10, 1'b0, 1'b0, R128_10);
        read_chk("inv0_128", 4'd0, 1'b1, 1'b0, R128_10);
        read_chk("r0_128", 4'd0, 1'b0, 1'b0, R128_0);
        read_chk("r1_128", 4'd1, 1'b0, 1'b0, R128_1);
        read_chk("r11_128", 4'd11, 1'b0, 1'b1, 128'd0);

        // Reads overlapping expansion, and a start while busy
        start_ks(2'd0, K128);
        for (int k = 1; k <= 44; k++) begin
            rd_en    = (k == 5) || (k == 16) || (k == 17);
            rd_round = 4'd3;
            start    = (k == 10);
            key_len  = 2'd2;
            key_in   = K256;
            tick();
            rd_en = 1'b0;
            start = 1'b0;
            if (k == 5)  chk("ovl_r3_early_err", 128'(rd_err), 128'd1);
            if (k == 16) chk("ovl_r3_same_cycle_err", 128'(rd_err), 128'd1);
            if (k == 17) begin
                chk("ovl_r3_err", 128'(rd_err), 128'd0);
                chk("ovl_r3_key", rd_key, R128_3);
            end
            if (k == 10) begin
                chk("ovl_busy_start_no_cfg_err", 128'(cfg_err), 128'd0);
                chk("ovl_busy_start_busy", 128'(busy), 128'd1);
            end
            if (k == 43) chk("ovl_done_early", 128'(done), 128'd0);
            if (k == 44) chk("ovl_done", 128'(done), 128'd1);
        end
        read_chk("ovl_r10", 4'd10, 1'b0, 1'b0, R128_10);
        read_chk("ovl_r14_err", 4'd14, 1'b0, 1'b1, 128'd0);

        // Reserved key length
        start_ks(2'd3, K256);
        chk("cfg_err_pulse", 128'(cfg_err), 128'd1);
        chk("cfg_err_busy", 128'(busy), 128'd0);
        tick();
        chk("cfg_err_clear", 128'(cfg_err), 128'd0);
        read_chk("cfg_err_keep_r10", 4'd10, 1'b0, 1'b0, R128_10);

        // AES-192
        start_ks(2'd1, K192);
        wait_done(cyc);
        chk("done_cyc_192", 128'(cyc), 128'd53);
        read_chk("r12_192", 4'd12, 1'b0, 1'b0, R192_12);
        read_chk("r13_192", 4'd13, 1'b0, 1'b1, 128'd0);
        read_chk("r1_192", 4'd1, 1'b0, 1'b0, R192_1);

        // AES-256
        start_ks(2'd2, K256);
        wait_done(cyc);
        chk("done_cyc_256", 128'(cyc), 128'd61);
        read_chk("r14_256", 4'd14, 1'b0, 1'b0, R256_14);
        read_chk("r0_256", 4'd0, 1'b0, 1'b0, R256_0);
        read_chk("r1_256", 4'd1, 1'b0, 1'b0, R256_1);
        read_chk("inv14_256", 4'd14, 1'b1, 1'b0, R256_0);

        // Zeroize mid-expansion
        start_ks(2'd0, K128);
        repeat (9) tick();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        nb   = 0;
        dcnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (done) dcnt++;
            if (!busy) break;
            nb++;
            tick();
        end
        for (int k = 0; k < 50; k++) begin
            tick();
            if (done) dcnt++;
        end
        chk("zero_busy_cycles", 128'(nb), 128'(ZERO_BUSY));
        chk("zero_no_done", 128'(dcnt), 128'd0);
        read_chk("zero_r0_err", 4'd0, 1'b0, 1'b1, 128'd0);
        start_ks(2'd0, K128);
        wait_done(cyc);
        chk("zero_fresh_done_cyc", 128'(cyc), 128'd45);
        read_chk("zero_fresh_r10", 4'd10, 1'b0, 1'b0, R128_10);

        // Asynchronous reset mid-expansion
        start_ks(2'd2, K256);
        repeat (18) tick();
        rd_en    = 1'b1;
        rd_round = 4'd0;
        tick();
        chk("pre_rst_vld", 128'(rd_valid), 128'd1);
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        chk("arst_busy",     128'(busy),     128'd0);
        chk("arst_done",     128'(done),     128'd0);
        chk("arst_cfg_err",  128'(cfg_err),  128'd0);
        chk("arst_rd_valid", 128'(rd_valid), 128'd0);
        chk("arst_rd_err",   128'(rd_err),   128'd0);
        chk("arst_rd_key",   rd_key,         128'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        read_chk("arst_r0_err", 4'd0, 1'b0, 1'b1, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
